// File: rtl/inst_queue_pkg.sv
// Shared sizing constants for the fetch-to-decode instruction queue.
package inst_queue_pkg;

  localparam int unsigned INST_QUEUE_SIZE  = 16;
  localparam int unsigned INST_QUEUE_IDX_W = 4;
  localparam int unsigned ID_WIDTH         = 32;
  localparam int unsigned ADDRESS_WIDTH    = 32;

endpackage

// File: rtl/inst_queue.sv
// Circular instruction FIFO between fetch and decode, flushed on any redirect.
// Fetch sees a one-cycle-early ready so its registered push never overflows.
module inst_queue
  import inst_queue_pkg::*;
#(
  parameter int unsigned DEPTH  = INST_QUEUE_SIZE,
  parameter int unsigned IDX_W  = INST_QUEUE_IDX_W,
  parameter int unsigned INST_W = ID_WIDTH,
  parameter int unsigned ADDR_W = ADDRESS_WIDTH
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              if_instqueue_en_in,
  input  logic [INST_W-1:0] if_instqueue_inst_in,
  input  logic [ADDR_W-1:0] if_instqueue_pc_in,
  output logic              instqueue_if_rdy_out,
  output logic              instqueue_decoder_en_out,
  output logic [INST_W-1:0] instqueue_decoder_inst_out,
  output logic [ADDR_W-1:0] instqueue_decoder_pc_out,
  input  logic              decoder_instqueue_rdy_in,
  input  logic              decoder_instqueue_clear_in,
  input  logic              rob_instqueue_clear_in
);

  logic [INST_W-1:0] inst_q [DEPTH];
  logic [ADDR_W-1:0] pc_q   [DEPTH];

  logic [IDX_W-1:0] head_q, head_d;
  logic [IDX_W-1:0] tail_q, tail_d;
  logic [IDX_W:0]   count_q, count_d;

  logic             clear;
  logic             full;
  logic             push;
  logic             pop;
  logic [IDX_W+1:0] fill_next;

  assign clear = decoder_instqueue_clear_in | rob_instqueue_clear_in;
  assign full  = (count_q == (IDX_W+1)'(DEPTH));

  assign instqueue_decoder_en_out = (count_q != '0);

  assign pop  = rdy_in & instqueue_decoder_en_out & decoder_instqueue_rdy_in & ~clear;
  assign push = rdy_in & if_instqueue_en_in & ~clear & (~full | pop);

  // Fetch's push lands one edge after it samples ready, so leave room for it.
  assign fill_next = {1'b0, count_q} + (IDX_W+2)'(if_instqueue_en_in);
  assign instqueue_if_rdy_out = clear | (fill_next <= (IDX_W+2)'(DEPTH - 2));

  assign instqueue_decoder_inst_out = instqueue_decoder_en_out ? inst_q[head_q] : '0;
  assign instqueue_decoder_pc_out   = instqueue_decoder_en_out ? pc_q[head_q]   : '0;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (rdy_in) begin
      if (clear) begin
        head_d  = '0;
        tail_d  = '0;
        count_d = '0;
      end else begin
        head_d  = head_q + IDX_W'(pop);
        tail_d  = tail_q + IDX_W'(push);
        count_d = count_q + (IDX_W+1)'(push) - (IDX_W+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately not reset; pointers alone define validity.
  always_ff @(posedge clk_in) begin
    if (push) begin
      inst_q[tail_q] <= if_instqueue_inst_in;
      pc_q[tail_q]   <= if_instqueue_pc_in;
    end
  end

  no_push_when_full: assert property (
    @(posedge clk_in) disable iff (rst_in)
      !(rdy_in && if_instqueue_en_in && !clear && full && !pop)
  );

endmodule

// File: tb/tb_inst_queue.sv
// Randomized and directed bench for inst_queue against a queue-based reference model.
module tb_inst_queue;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        if_en;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_rdy_out;
  logic        dec_en_out;
  logic [31:0] dec_inst_out;
  logic [31:0] dec_pc_out;
  logic        dec_rdy;
  logic        dec_clr;
  logic        rob_clr;

  inst_queue dut (
    .clk_in                     (clk),
    .rst_in                     (rst),
    .rdy_in                     (rdy),
    .if_instqueue_en_in         (if_en),
    .if_instqueue_inst_in       (if_inst),
    .if_instqueue_pc_in         (if_pc),
    .instqueue_if_rdy_out       (if_rdy_out),
    .instqueue_decoder_en_out   (dec_en_out),
    .instqueue_decoder_inst_out (dec_inst_out),
    .instqueue_decoder_pc_out   (dec_pc_out),
    .decoder_instqueue_rdy_in   (dec_rdy),
    .decoder_instqueue_clear_in (dec_clr),
    .rob_instqueue_clear_in     (rob_clr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: plain FIFO of (pc, inst) pairs
  logic [31:0] m_pc[$];
  logic [31:0] m_inst[$];

  logic [31:0] next_pc  = 32'h0;
  logic        fetch_ok = 1'b0;
  logic        chk_on   = 1'b0;
  logic        track_seq = 1'b0;
  logic [31:0] seq_exp  = 32'h0;
  logic        seen_wrong = 1'b0;
  int          pops_seen = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic en, input logic d_rdy, input logic d_clr,
                      input logic r_clr, input logic g_rdy, input logic g_rst);
    logic        e_en;
    logic        e_rdy;
    logic [31:0] e_pc;
    logic [31:0] e_inst;
    logic        clr;
    logic        do_pop;
    logic        do_push;
    @(negedge clk);
    if_en   = en;
    if_inst = $urandom;
    if_pc   = next_pc;
    dec_rdy = d_rdy;
    dec_clr = d_clr;
    rob_clr = r_clr;
    rdy     = g_rdy;
    rst     = g_rst;
    clr     = d_clr | r_clr;
    e_en    = (m_pc.size() != 0);
    e_pc    = e_en ? m_pc[0] : 32'h0;
    e_inst  = e_en ? m_inst[0] : 32'h0;
    e_rdy   = clr || ((m_pc.size() + int'(en)) <= DEPTH - 2);
    #1;
    if (chk_on) begin
      check_val("en_out",   64'(dec_en_out),   64'(e_en));
      check_val("pc_out",   64'(dec_pc_out),   64'(e_pc));
      check_val("inst_out", 64'(dec_inst_out), 64'(e_inst));
      check_val("rdy_out",  64'(if_rdy_out),   64'(e_rdy));
    end
    if (dec_en_out && dec_pc_out == 32'h100) seen_wrong = 1'b1;
    @(posedge clk);
    do_pop  = 1'b0;
    do_push = 1'b0;
    if (g_rst) begin
      m_pc.delete();
      m_inst.delete();
      fetch_ok = 1'b0;
    end else if (g_rdy) begin
      if (clr) begin
        m_pc.delete();
        m_inst.delete();
      end else begin
        do_pop  = e_en && d_rdy;
        do_push = en && (m_pc.size() < DEPTH || do_pop);
        if (do_pop) begin
          if (track_seq) begin
            check_val("seq_pc", 64'(e_pc), 64'(seq_exp));
            seq_exp += 32'h4;
          end
          pops_seen++;
          void'(m_pc.pop_front());
          void'(m_inst.pop_front());
        end
        if (do_push) begin
          m_pc.push_back(if_pc);
          m_inst.push_back(if_inst);
          next_pc += 32'h4;
        end
      end
      fetch_ok = e_rdy;
    end
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; if_en = 1'b0; if_inst = '0; if_pc = '0;
    dec_rdy = 1'b0; dec_clr = 1'b0; rob_clr = 1'b0;
    do_reset();
    chk_on = 1'b1;
    do_reset();

    // three pushes with decoder stalled
    next_pc = 32'h0;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    // keep pushing while fetch is allowed, then drain
    repeat (20) step(fetch_ok, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    pops_seen = 0;
    repeat (20) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("stall_fill_count", 64'(pops_seen), 64'd15);

    // push and pop every cycle, wrapping the pointers
    do_reset();
    next_pc = 32'h0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    track_seq = 1'b1;
    seq_exp   = 32'h0;
    repeat (40) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    track_seq = 1'b0;
    check_val("seq_pops", 64'(seq_exp), 64'h0A0);

    // flush with a wrong-path push and a pop, via ROB then decoder
    for (int k = 0; k < 2; k++) begin
      do_reset();
      seen_wrong = 1'b0;
      next_pc = 32'h10;
      repeat (5) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      next_pc = 32'h100;
      step(1'b1, 1'b1, k == 1, k == 0, 1'b1, 1'b0);
      next_pc = 32'h200;
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check_val("flush_empty", 64'(dec_en_out), 64'd0);
      repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      check_val("wrong_path_seen", 64'(seen_wrong), 64'd0);
    end

    // global stall with push and pop requested
    do_reset();
    next_pc = 32'h300;
    repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // reset mid-stream
    do_reset();
    next_pc = 32'h400;
    repeat (7) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("rst_en",   64'(dec_en_out),   64'd0);
    check_val("rst_pc",   64'(dec_pc_out),   64'd0);
    check_val("rst_inst", 64'(dec_inst_out), 64'd0);
    check_val("rst_rdy",  64'(if_rdy_out),   64'd1);

    // randomized traffic obeying the fetch ready protocol
    next_pc = 32'h1000;
    for (int i = 0; i < 1500; i++) begin
      logic r_en, r_dr, r_dc, r_rc, r_g, r_rst;
      r_rst = ($urandom_range(0, 199) == 0);
      r_g   = ($urandom_range(0, 9) != 0);
      r_dr  = ($urandom_range(0, 99) < ((i / 250) % 2 == 0 ? 60 : 15));
      r_dc  = ($urandom_range(0, 59) == 0);
      r_rc  = ($urandom_range(0, 59) == 0);
      if (!rdy && !rst) r_en = if_en;
      else r_en = fetch_ok && ($urandom_range(0, 3) != 0);
      step(r_en, r_dr, r_dc, r_rc, r_g, r_rst);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
